serial_subtractor: RTL



---
 rtl/serial_subtractor_if.sv | 40 ++++
 rtl/serial_subtractor.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the digit-serial subtractor.
// The master side issues a start with its operands and watches busy/done;
// the slave side (the subtractor) returns the difference and status flags.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output a,
        output b,
        output bin,
        input  diff,
        input  bout,
        input  ovf,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        input  bin,
        output diff,
        output bout,
        output ovf,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: computes a - b - bin over WIDTH/CHUNK clock cycles,
// CHUNK bits at a time starting from the LSB, chaining the borrow between
// chunks through a register. Result bits enter diff from the MSB side so the
// word is aligned once the last chunk has been shifted in.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(N - 1);

    // Reject parameter combinations that cannot be split into whole chunks.
    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("serial_subtractor: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CHUNK-1:0] chunk_diff;
    logic             chunk_bout;
    logic             msb_bin;
    logic             ripple;

    // Ripple of CHUNK full-subtractor cells over the low bits of the operands;
    // also keeps the borrow entering the top cell for the overflow flag.
    always_comb begin
        chunk_diff = '0;
        msb_bin    = 1'b0;
        ripple     = borrow_q;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                msb_bin = ripple;
            end
            chunk_diff[i] = a_q[i] ^ b_q[i] ^ ripple;
            ripple        = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & ripple);
        end
        chunk_bout = ripple;
    end

    // Next-state logic: load operands on an accepted start, then consume one
    // chunk per cycle; the final chunk publishes bout/ovf and pulses done.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        count_d  = count_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    borrow_d = bus.bin;
                    count_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end

            RUN: begin
                diff_d   = (diff_q >> CHUNK) | (WIDTH'(chunk_diff) << (WIDTH - CHUNK));
                a_d      = a_q >> CHUNK;
                b_d      = b_q >> CHUNK;
                borrow_d = chunk_bout;
                count_d  = count_q + CNT_W'(1);
                if (count_q == LAST_COUNT) begin
                    bout_d  = chunk_bout;
                    ovf_d   = msb_bin ^ chunk_bout;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, including an
    // operation that is still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            count_q  <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            count_q  <= count_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
